hex_seg_display_ctrl: RTL and testbench



---
 rtl/hex_seg_display_ctrl.sv | 149 ++++++++++++++
 tb/tb_hex_seg_display_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_seg_display_ctrl.sv
// Four-digit seven-segment output stage: per-digit blink, global PWM dimming and timed lamp-test.
// Latency: one clk from any input to hex*; no backpressure, the display follows seg_in every clk.
module hex_seg_display_ctrl #(
    parameter int TICK_DIV    = 3125,
    parameter int BLINK_TICKS = 8000,
    parameter int LAMP_TICKS  = 16000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [27:0] seg_in,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dim_level,
    input  logic        lamp_test_req,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic        lamp_busy
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int LMP_W = (LAMP_TICKS > 1) ? $clog2(LAMP_TICKS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_TICKS - 1);
    localparam logic [LMP_W-1:0] LAMP_LAST  = LMP_W'(LAMP_TICKS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LAMP = 1'b1;

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       pwm_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;
    logic             tick;
    logic             pwm_on;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [LMP_W-1:0] lamp_cnt;
    logic [LMP_W-1:0] lamp_cnt_nxt;

    logic [3:0][6:0]  hex_nxt;

    assign tick   = (div_cnt == DIV_LAST);
    assign pwm_on = (pwm_cnt <= dim_level);

    // Disabling the display parks every timer at phase 0 so re-enable is deterministic.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_cnt     <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                pwm_cnt <= pwm_cnt + 4'd1;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        lamp_cnt_nxt = lamp_cnt;
        if (!enable) begin
            state_nxt    = ST_IDLE;
            lamp_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lamp_test_req) begin
                        state_nxt    = ST_LAMP;
                        lamp_cnt_nxt = '0;
                    end
                end
                ST_LAMP: begin
                    if (tick) begin
                        if (lamp_cnt == LAMP_LAST) begin
                            state_nxt    = ST_IDLE;
                            lamp_cnt_nxt = '0;
                        end else begin
                            lamp_cnt_nxt = lamp_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    lamp_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            lamp_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lamp_cnt <= lamp_cnt_nxt;
        end
    end

    assign lamp_busy = (state == ST_LAMP);

    // Lamp selection uses the next state so the digits and lamp_busy change on the same clk.
    always_comb begin
        hex_nxt = '1;
        for (int i = 0; i < 4; i++) begin
            if (!enable) begin
                hex_nxt[i] = 7'h7F;
            end else if (state_nxt == ST_LAMP) begin
                hex_nxt[i] = 7'h00;
            end else if (blink_mask[i] && blink_phase) begin
                hex_nxt[i] = 7'h7F;
            end else if (!pwm_on) begin
                hex_nxt[i] = 7'h7F;
            end else begin
                hex_nxt[i] = seg_in[7*i +: 7];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex0 <= 7'h7F;
            hex1 <= 7'h7F;
            hex2 <= 7'h7F;
            hex3 <= 7'h7F;
        end else begin
            hex0 <= hex_nxt[0];
            hex1 <= hex_nxt[1];
            hex2 <= hex_nxt[2];
            hex3 <= hex_nxt[3];
        end
    end

endmodule

// File: tb/tb_hex_seg_display_ctrl.sv
// Directed bench for hex_seg_display_ctrl with TICK_DIV=4, BLINK_TICKS=4, LAMP_TICKS=8.
module tb_hex_seg_display_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [27:0] seg_in;
    logic [3:0]  blink_mask;
    logic [3:0]  dim_level;
    logic        lamp_test_req;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic        lamp_busy;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    localparam logic [27:0] ALL_OFF = 28'hFFF_FFFF;

    always #5 clk = ~clk;

    hex_seg_display_ctrl #(
        .TICK_DIV   (4),
        .BLINK_TICKS(4),
        .LAMP_TICKS (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .seg_in       (seg_in),
        .blink_mask   (blink_mask),
        .dim_level    (dim_level),
        .lamp_test_req(lamp_test_req),
        .hex0         (hex0),
        .hex1         (hex1),
        .hex2         (hex2),
        .hex3         (hex3),
        .lamp_busy    (lamp_busy)
    );

    typedef struct {
        logic [27:0] seg;
        logic        en;
        logic [3:0]  dim;
        logic [27:0] exp;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [27:0] hexw();
        return {hex3, hex2, hex1, hex0};
    endfunction

    // Expected word kk edges after timers restarted: pwm steps every 4 clks, blink phase every 16.
    function automatic logic [27:0] model(int kk, logic [3:0] dim, logic [3:0] mask, logic [27:0] seg);
        logic [27:0] w;
        int pwm;
        int ph;
        pwm = ((kk - 1) / 4) % 16;
        ph  = ((kk - 1) / 16) % 2;
        w   = seg;
        for (int i = 0; i < 4; i++) begin
            if ((pwm > int'(dim)) || (mask[i] && ph == 1))
                w[7*i +: 7] = 7'h7F;
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic restart_timing();
        enable = 1'b0;
        step();
        enable = 1'b1;
        k = 0;
    endtask

    task automatic run_model(input int n, input string name);
        for (int j = 0; j < n; j++) begin
            step();
            chk(name, {4'h0, hexw()}, {4'h0, model(k, dim_level, blink_mask, seg_in)});
        end
    endtask

    initial begin
        int dur;

        tbl[0] = '{{7'h40, 7'h79, 7'h24, 7'h30}, 1'b1, 4'd15, {7'h40, 7'h79, 7'h24, 7'h30}};
        tbl[1] = '{{7'h12, 7'h02, 7'h78, 7'h00}, 1'b1, 4'd15, {7'h12, 7'h02, 7'h78, 7'h00}};
        tbl[2] = '{{7'h7F, 7'h00, 7'h7F, 7'h00}, 1'b1, 4'd15, {7'h7F, 7'h00, 7'h7F, 7'h00}};
        tbl[3] = '{{7'h08, 7'h03, 7'h46, 7'h21}, 1'b0, 4'd15, ALL_OFF};
        tbl[4] = '{{7'h08, 7'h03, 7'h46, 7'h21}, 1'b1, 4'd15, {7'h08, 7'h03, 7'h46, 7'h21}};
        tbl[5] = '{{7'h19, 7'h0E, 7'h06, 7'h10}, 1'b1, 4'd15, {7'h19, 7'h0E, 7'h06, 7'h10}};

        reset         = 1'b1;
        enable        = 1'b0;
        seg_in        = 28'h0;
        blink_mask    = 4'h0;
        dim_level     = 4'h0;
        lamp_test_req = 1'b0;

        // Reset held for two clks
        for (int j = 0; j < 2; j++) begin
            step();
            chk("reset_hex", {4'h0, hexw()}, {4'h0, ALL_OFF});
            chk("reset_busy", {31'h0, lamp_busy}, 32'h0);
        end
        reset = 1'b0;
        #2;
        chk("post_reset_hex", {4'h0, hexw()}, {4'h0, ALL_OFF});
        chk("post_reset_busy", {31'h0, lamp_busy}, 32'h0);
        step();
        chk("post_reset_hex_clk", {4'h0, hexw()}, {4'h0, ALL_OFF});

        // Passthrough table
        blink_mask = 4'h0;
        for (int v = 0; v < 6; v++) begin
            seg_in    = tbl[v].seg;
            enable    = tbl[v].en;
            dim_level = tbl[v].dim;
            step();
            chk($sformatf("table_%0d_hex", v), {4'h0, hexw()}, {4'h0, tbl[v].exp});
            chk($sformatf("table_%0d_busy", v), {31'h0, lamp_busy}, 32'h0);
        end

        // Dimming: 16 clks lit, 48 dark, repeating every 64
        seg_in     = {7'h40, 7'h79, 7'h24, 7'h30};
        dim_level  = 4'd3;
        blink_mask = 4'h0;
        restart_timing();
        for (int j = 1; j <= 80; j++) begin
            step();
            chk("dim3", {4'h0, hexw()},
                {4'h0, (((j - 1) % 64) < 16) ? seg_in : ALL_OFF});
        end

        // Blink on digits 0 and 2, 16 clks per half-period
        dim_level  = 4'd15;
        blink_mask = 4'b0101;
        restart_timing();
        for (int j = 1; j <= 48; j++) begin
            step();
            chk("blink0101", {4'h0, hexw()},
                {4'h0, (((j - 1) / 16) % 2 == 1) ? {seg_in[27:21], 7'h7F, seg_in[13:7], 7'h7F} : seg_in});
        end

        // Lamp test with a second request mid-test
        restart_timing();
        run_model(5, "pre_lamp");
        lamp_test_req = 1'b1;
        step();
        lamp_test_req = 1'b0;
        chk("lamp_start_busy", {31'h0, lamp_busy}, 32'h1);
        chk("lamp_start_hex", {4'h0, hexw()}, 32'h0);
        dur = 1;
        while (lamp_busy === 1'b1 && dur < 100) begin
            lamp_test_req = (dur == 12);
            step();
            lamp_test_req = 1'b0;
            if (lamp_busy === 1'b1) begin
                dur++;
                chk("lamp_hex_on", {4'h0, hexw()}, 32'h0);
            end
        end
        chk("lamp_duration_in_range", {31'h0, (dur >= 28 && dur <= 36)}, 32'h1);
        chk("lamp_exit_hex", {4'h0, hexw()}, {4'h0, model(k, dim_level, blink_mask, seg_in)});
        run_model(20, "post_lamp");

        // Enable dropped during lamp-test
        restart_timing();
        run_model(3, "pre_lamp2");
        lamp_test_req = 1'b1;
        step();
        lamp_test_req = 1'b0;
        for (int j = 0; j < 5; j++) step();
        chk("lamp2_busy", {31'h0, lamp_busy}, 32'h1);
        enable = 1'b0;
        step();
        chk("disable_hex", {4'h0, hexw()}, {4'h0, ALL_OFF});
        chk("disable_busy", {31'h0, lamp_busy}, 32'h0);
        enable = 1'b1;
        k = 0;
        run_model(20, "reenable");
        chk("reenable_busy", {31'h0, lamp_busy}, 32'h0);

        // Reset during lamp-test, then request coinciding with reset
        lamp_test_req = 1'b1;
        step();
        lamp_test_req = 1'b0;
        step();
        step();
        chk("lamp3_busy", {31'h0, lamp_busy}, 32'h1);
        reset = 1'b1;
        step();
        chk("reset_mid_lamp_busy", {31'h0, lamp_busy}, 32'h0);
        chk("reset_mid_lamp_hex", {4'h0, hexw()}, {4'h0, ALL_OFF});
        lamp_test_req = 1'b1;
        step();
        lamp_test_req = 1'b0;
        reset = 1'b0;
        chk("req_with_reset_busy", {31'h0, lamp_busy}, 32'h0);
        k = 0;
        step();
        chk("after_reset_busy", {31'h0, lamp_busy}, 32'h0);
        chk("after_reset_hex", {4'h0, hexw()}, {4'h0, model(k, dim_level, blink_mask, seg_in)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
